// File: rtl/uart_buffer_arbiter.sv
// rtl/uart_buffer_arbiter.sv - round-robin sequencer sharing the UART ring buffer between two writers and one reader
module uart_buffer_arbiter #(
  parameter int CAPACITY = 254
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr0_valid,
  input  logic [7:0] wr0_data,
  output logic       wr0_done,
  input  logic       wr1_valid,
  input  logic [7:0] wr1_data,
  output logic       wr1_done,
  output logic       wr_drop,
  input  logic       rd_req,
  output logic       rd_done,
  output logic       rd_ok,
  output logic [7:0] rd_data,
  output logic       buf_write_enable,
  output logic [7:0] buf_write_data,
  output logic       buf_read_enable,
  input  logic       buf_read_ack,
  input  logic [7:0] buf_read_data,
  output logic [7:0] count,
  output logic       full,
  output logic       empty
);

  localparam logic [7:0] CAP = 8'(CAPACITY);

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, READ_DONE} state_t;
  typedef enum logic [1:0] {P_WR0, P_WR1, P_RD} src_t;

  state_t state;
  src_t   ptr;
  src_t   win;
  logic   any;

  // Search starts at the requester after the last winner: WR0 -> WR1 -> RD -> WR0
  always_comb begin
    any = 1'b0;
    win = P_WR0;
    case (ptr)
      P_WR0: begin
        if (wr1_valid)      begin any = 1'b1; win = P_WR1; end
        else if (rd_req)    begin any = 1'b1; win = P_RD;  end
        else if (wr0_valid) begin any = 1'b1; win = P_WR0; end
      end
      P_WR1: begin
        if (rd_req)         begin any = 1'b1; win = P_RD;  end
        else if (wr0_valid) begin any = 1'b1; win = P_WR0; end
        else if (wr1_valid) begin any = 1'b1; win = P_WR1; end
      end
      default: begin
        if (wr0_valid)      begin any = 1'b1; win = P_WR0; end
        else if (wr1_valid) begin any = 1'b1; win = P_WR1; end
        else if (rd_req)    begin any = 1'b1; win = P_RD;  end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= P_RD;
      wr0_done         <= 1'b0;
      wr1_done         <= 1'b0;
      wr_drop          <= 1'b0;
      rd_done          <= 1'b0;
      rd_ok            <= 1'b0;
      rd_data          <= 8'h00;
      buf_write_enable <= 1'b0;
      buf_write_data   <= 8'h00;
      buf_read_enable  <= 1'b0;
      count            <= 8'h00;
      full             <= 1'b0;
      empty            <= 1'b1;
    end else begin
      wr0_done         <= 1'b0;
      wr1_done         <= 1'b0;
      wr_drop          <= 1'b0;
      rd_done          <= 1'b0;
      rd_ok            <= 1'b0;
      buf_write_enable <= 1'b0;
      buf_read_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            ptr <= win;
            if (win == P_RD) begin
              buf_read_enable <= 1'b1;
              state           <= READ;
            end else begin
              state    <= WRITE;
              wr0_done <= (win == P_WR0);
              wr1_done <= (win == P_WR1);
              if (full) begin
                wr_drop <= 1'b1;
              end else begin
                buf_write_enable <= 1'b1;
                buf_write_data   <= (win == P_WR0) ? wr0_data : wr1_data;
                count            <= count + 8'd1;
                full             <= (count + 8'd1 == CAP);
                empty            <= 1'b0;
              end
            end
          end
        end
        WRITE:     state <= IDLE;
        READ:      state <= READ_WAIT;
        READ_WAIT: begin
          rd_done <= 1'b1;
          rd_ok   <= buf_read_ack;
          // Only an acknowledged read removes a byte; count is guarded against underflow
          if (buf_read_ack) begin
            rd_data <= buf_read_data;
            if (count != 8'h00) begin
              count <= count - 8'd1;
              full  <= 1'b0;
              empty <= (count == 8'd1);
            end
          end
          state <= READ_DONE;
        end
        READ_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_buffer_arbiter.md
# uart_buffer_arbiter

Sequencer that shares the single-port UART ring buffer between two byte writers (CPU store path, receive path) and one byte reader (transmit/CPU load path). Serialises all accesses so the buffer never sees a write and a read in the same cycle, applies three-way round-robin arbitration, and tracks occupancy so writes to a full buffer are dropped and reported instead of silently lost. Sits directly in front of the ring buffer; the ring buffer and this block share `clk` and `reset`.

## Interface
- `CAPACITY`, 254: maximum bytes admitted; must be ≤ 254 (ring buffer's usable depth)
- `clk` in 1: global clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `wr0_valid` in 1: writer 0 request; held with `wr0_data` until `wr0_done`
- `wr0_data` in 8: writer 0 byte
- `wr0_done` out 1: one-cycle pulse, writer 0 transaction complete
- `wr1_valid`, `wr1_data`, `wr1_done`: same as writer 0
- `wr_drop` out 1: valid with a `wrN_done` pulse; 1 = byte discarded (full)
- `rd_req` in 1: reader request; held until `rd_done`
- `rd_done` out 1: one-cycle pulse, read complete
- `rd_ok` out 1: valid with `rd_done`; 1 = `rd_data` holds a byte, 0 = buffer empty
- `rd_data` out 8: byte read; holds last value otherwise
- `buf_write_enable` out 1: to ring buffer write enable
- `buf_write_data` out 8: to ring buffer write data
- `buf_read_enable` out 1: to ring buffer read enable
- `buf_read_ack` in 1: from ring buffer read ack (registered in buffer)
- `buf_read_data` in 8: from ring buffer read data
- `count` out 8: bytes currently admitted, 0..CAPACITY
- `full` out 1: `count == CAPACITY`; `empty` out 1: `count == 0`

## Operation
- All outputs registered. Reset values: every pulse/enable output 0, `rd_data`/`buf_write_data` 0, `count` 0, `empty` 1, `full` 0, state IDLE, round-robin pointer = RD.
- States: IDLE, WRITE, READ, READ_WAIT, READ_DONE.
- IDLE: candidates ordered WR0 → WR1 → RD, search begins at entry after the pointer; first asserted request wins; pointer ← winner. No request: stay IDLE.
- IDLE → WRITE (winner WRN): if `full`, no buffer write, set `wrN_done`=1, `wr_drop`=1; else `buf_write_enable`=1, `buf_write_data`=`wrN_data`, `wrN_done`=1, `wr_drop`=0, `count`+1. WRITE → IDLE unconditionally.
- IDLE → READ (winner RD): `buf_read_enable`=1. READ → READ_WAIT (enable deasserted). READ_WAIT: sample `buf_read_ack`/`buf_read_data`; `rd_done`=1, `rd_ok`=ack, `rd_data`=data if ack; `count`−1 if ack; → READ_DONE. READ_DONE → IDLE.
- `buf_write_enable` and `buf_read_enable` never both 1; at most one transaction in flight.
- `count` never exceeds CAPACITY nor underflows (decrement only on ack).
- A request deasserted before its done pulse while not yet granted is simply not served; once granted the transaction completes.
- Reset mid-transaction: abandon immediately, no done pulse, return to reset values.

## Timing
- Write: request seen in IDLE at cycle T; `buf_write_enable`, `wrN_done`, `count` update visible T+1; IDLE again T+2. Requester must drop valid by T+2 edge; still high at T+2 = new request.
- Read: grant at T; `buf_read_enable` high T+1; buffer ack visible T+2 (sampled in READ_WAIT); `rd_done`/`rd_ok`/`rd_data` visible T+3; IDLE T+4.
- Back-to-back writes from one writer with the other idle: one byte per 2 cycles. Read: one per 4 cycles.
- All three requesting continuously: grants rotate WR0, WR1, RD, WR0, ...

## Test plan
- Reset, `wr0_valid`=1 data 0x41 at T → `buf_write_enable`=1, `buf_write_data`=0x41, `wr0_done`=1, `wr_drop`=0 at T+1; `count`=1, `empty`=0.
- Write 0x10, 0x20 via wr1, then `rd_req` → `rd_done` at grant+3 with `rd_ok`=1, `rd_data`=0x10; second read returns 0x20; `count`=0.
- `rd_req` with empty buffer → `rd_done`=1, `rd_ok`=0, `rd_data` unchanged, `count` stays 0.
- CAPACITY=4: five writes → first four `wr_drop`=0, fifth `wr_drop`=1 with no `buf_write_enable`; `full`=1, `count`=4.
- All three requesters held high from reset → grant order WR0, WR1, RD, WR0; never both buffer enables high.
- Assert `reset` during READ_WAIT → all outputs to reset values same cycle, no `rd_done`; next request served normally starting from WR0 priority.
